// File: rtl/datawidthconv_512_to_32.sv
// Buffers a packet of up to 32 512-bit beats, then drains it as 32-bit writes.
// Define DATAWIDTHCONV_512_TO_32_ERRCNT_EN to add the saturating err_cnt output.
module datawidthconv_512_to_32 (
  input  logic         clk,
  input  logic         reset,
  input  logic         snk_valid,
  input  logic         snk_sop,
  input  logic         snk_eop,
  input  logic [511:0] snk_d,
  output logic         snk_ready,
  input  logic [31:0]  base_addr,
  output logic [31:0]  data_addr,
  output logic         data_we,
  output logic [31:0]  data_d,
  output logic         busy,
  output logic         done,
  output logic         err
`ifdef DATAWIDTHCONV_512_TO_32_ERRCNT_EN
  ,
  output logic [15:0]  err_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRecv, StDrain} state_e;

  state_e       state_q;
  logic         ready_q, we_q, busy_q, done_q, err_q;
  logic [31:0]  addr_q, dout_q, base_q;
  logic [4:0]   beat_q, last_q;
  logic [9:0]   wcnt_q;
  logic [511:0] mem_q [32];

  logic         accept;
  logic         ev_stray, ev_sop, ev_ovf;
  logic         mem_we;
  logic [4:0]   mem_idx;
  logic [9:0]   drain_len;
  logic [511:0] rd_beat;
  logic [31:0]  rd_word;

  assign accept    = snk_valid && ready_q;
  assign ev_stray  = accept && (state_q == StIdle) && !snk_sop;
  assign ev_sop    = accept && (state_q == StRecv) && snk_sop;
  assign ev_ovf    = accept && (state_q == StRecv) && !snk_eop && (beat_q == 5'd31);
  assign mem_we    = accept && ((state_q == StRecv) || ((state_q == StIdle) && snk_sop));
  assign mem_idx   = (state_q == StIdle) ? 5'd0 : beat_q;
  assign drain_len = {1'b0, last_q, 4'b0000} + 10'd16;

  always_comb begin
    rd_beat = mem_q[wcnt_q[8:4]];
    rd_word = rd_beat[{wcnt_q[3:0], 5'd0} +: 32];
  end

  // Packet storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= snk_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      base_q  <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (ev_stray || ev_sop || ev_ovf) err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept && snk_sop) begin
            base_q <= base_addr;
            beat_q <= 5'd1;
            wcnt_q <= '0;
            busy_q <= 1'b1;
            if (snk_eop) begin
              last_q  <= 5'd0;
              state_q <= StDrain;
              ready_q <= 1'b0;
            end else begin
              state_q <= StRecv;
            end
          end
        end
        StRecv: begin
          if (accept) begin
            beat_q <= beat_q + 5'd1;
            // A 32nd beat without eop closes the packet anyway.
            if (snk_eop || beat_q == 5'd31) begin
              last_q  <= beat_q;
              wcnt_q  <= '0;
              state_q <= StDrain;
              ready_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (wcnt_q == drain_len) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            we_q   <= 1'b1;
            addr_q <= base_q + {20'd0, wcnt_q, 2'b00};
            dout_q <= rd_word;
            wcnt_q <= wcnt_q + 10'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign snk_ready = ready_q;
  assign data_we   = we_q;
  assign data_addr = addr_q;
  assign data_d    = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef DATAWIDTHCONV_512_TO_32_ERRCNT_EN
  logic [15:0] errcnt_q;
  logic [16:0] errcnt_sum;

  assign errcnt_sum = {1'b0, errcnt_q} + {16'd0, ev_stray} + {16'd0, ev_sop} + {16'd0, ev_ovf};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_sum[16] ? 16'hFFFF : errcnt_sum[15:0];
    end
  end

  assign err_cnt = errcnt_q;
`endif

endmodule
